// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Fetch-side next-PC predictor built from a direct-mapped BTB. Each entry
//   holds a 2-bit saturating direction counter. The MEM stage resolution
//   trains the table and is checked against the prediction that travelled
//   down the pipe with the instruction. A wrong prediction raises a registered
//   one-cycle flush together with the correct redirect PC.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   if_pc             PC being fetched (combinational lookup, 0 cycles)
//   pred_taken        BTB hit and (jump entry or counter in a taken state)
//   pred_target       BTB target on hit, else 0
//   pred_next_pc      pred_taken ? pred_target : if_pc + 4
//   mem_*             resolved instruction in MEM plus its carried prediction
//   flush             registered one-cycle squash of IF/ID/EX
//   redirect_pc       registered correct next PC, meaningful while flush=1
//   stat_branches     resolved branches + jumps (wraps)
//   stat_mispredicts  mispredictions that caused a flush (wraps)
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int IDX_BITS = 6,
   parameter int TAG_BITS = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic [31:0] pred_next_pc,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_isbranch,
   input  logic        mem_isjump,
   input  logic        mem_pcsrc,
   input  logic [31:0] mem_target,
   input  logic        mem_pred_taken,
   input  logic [31:0] mem_pred_target,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_LO  = IDX_BITS + 2;
   localparam int TAG_HI  = IDX_BITS + 2 + TAG_BITS - 1;

   // Saturating increment of a 2-bit direction counter.
   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'd1;
   endfunction

   // Saturating decrement of a 2-bit direction counter.
   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'd1;
   endfunction

   // Table storage is flop-based so reset clears every entry.
   logic                valid_q  [ENTRIES];
   logic                jump_q   [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic        flush_q,       flush_d;
   logic [31:0] redirect_q,    redirect_d;
   logic [31:0] stat_br_q,     stat_br_d;
   logic [31:0] stat_mp_q,     stat_mp_d;

   logic [IDX_BITS-1:0] if_idx_s,  mem_idx_s;
   logic [TAG_BITS-1:0] if_tag_s,  mem_tag_s;
   logic                if_hit_s,  mem_hit_s;
   logic                upd_s, ctrl_s, mp_s;
   logic                wr_en_s, wr_valid_s, wr_jump_s;
   logic [TAG_BITS-1:0] wr_tag_s;
   logic [31:0]         wr_target_s;
   logic [1:0]          wr_ctr_s;
   logic                unused_s;

   assign unused_s = ^{if_pc[1:0], mem_pc[1:0]};

   assign if_idx_s  = if_pc[IDX_BITS+1:2];
   assign if_tag_s  = if_pc[TAG_HI:TAG_LO];
   assign mem_idx_s = mem_pc[IDX_BITS+1:2];
   assign mem_tag_s = mem_pc[TAG_HI:TAG_LO];

   // IF lookup: reads pre-edge contents, so a same-cycle MEM write is not seen.
   always_comb begin
      if_hit_s     = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
      pred_taken   = if_hit_s && (jump_q[if_idx_s] || ctr_q[if_idx_s][1]);
      pred_target  = if_hit_s ? target_q[if_idx_s] : 32'd0;
      pred_next_pc = pred_taken ? pred_target : if_pc + 32'd4;
   end

   // Resolution check; inputs seen during a flush cycle are wrong-path.
   always_comb begin
      upd_s     = mem_valid && !flush_q;
      ctrl_s    = mem_isbranch || mem_isjump;
      mem_hit_s = valid_q[mem_idx_s] && (tag_q[mem_idx_s] == mem_tag_s);
      if (ctrl_s) begin
         mp_s = (mem_pcsrc != mem_pred_taken) ||
                (mem_pcsrc && mem_pred_taken && (mem_target != mem_pred_target));
      end else begin
         // A taken prediction on a non-control instruction is a BTB alias.
         mp_s = mem_pred_taken;
      end
   end

   // Table write selection; one entry at mem_pc's index per cycle at most.
   always_comb begin
      wr_en_s     = 1'b0;
      wr_valid_s  = valid_q[mem_idx_s];
      wr_jump_s   = jump_q[mem_idx_s];
      wr_tag_s    = tag_q[mem_idx_s];
      wr_target_s = target_q[mem_idx_s];
      wr_ctr_s    = ctr_q[mem_idx_s];
      if (!upd_s) begin
         wr_en_s = 1'b0;
      end else if (mem_isjump) begin
         wr_en_s     = 1'b1;
         wr_valid_s  = 1'b1;
         wr_jump_s   = 1'b1;
         wr_tag_s    = mem_tag_s;
         wr_target_s = mem_target;
         wr_ctr_s    = 2'b11;
      end else if (mem_isbranch && mem_hit_s) begin
         wr_en_s     = 1'b1;
         wr_ctr_s    = mem_pcsrc ? ctr_inc(ctr_q[mem_idx_s]) : ctr_dec(ctr_q[mem_idx_s]);
         wr_target_s = mem_pcsrc ? mem_target : target_q[mem_idx_s];
      end else if (mem_isbranch && mem_pcsrc) begin
         wr_en_s     = 1'b1;
         wr_valid_s  = 1'b1;
         wr_jump_s   = 1'b0;
         wr_tag_s    = mem_tag_s;
         wr_target_s = mem_target;
         wr_ctr_s    = 2'b10;
      end else if (!mem_isbranch && mem_pred_taken && mem_hit_s) begin
         wr_en_s    = 1'b1;
         wr_valid_s = 1'b0;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Flush, redirect and statistics next-state.
   always_comb begin
      flush_d    = upd_s && mp_s;
      redirect_d = redirect_q;
      stat_br_d  = stat_br_q;
      stat_mp_d  = stat_mp_q;
      if (upd_s && mp_s) begin
         redirect_d = (ctrl_s && mem_pcsrc) ? mem_target : mem_pc + 32'd4;
         stat_mp_d  = stat_mp_q + 32'd1;
      end else begin
         redirect_d = redirect_q;
      end
      if (upd_s && ctrl_s) begin
         stat_br_d = stat_br_q + 32'd1;
      end else begin
         stat_br_d = stat_br_q;
      end
   end

   // BTB entry registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            jump_q[i]   <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'd0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (wr_en_s) begin
         valid_q[mem_idx_s]  <= wr_valid_s;
         jump_q[mem_idx_s]   <= wr_jump_s;
         tag_q[mem_idx_s]    <= wr_tag_s;
         target_q[mem_idx_s] <= wr_target_s;
         ctr_q[mem_idx_s]    <= wr_ctr_s;
      end
   end

   // Flush/redirect/statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q    <= 1'b0;
         redirect_q <= 32'd0;
         stat_br_q  <= 32'd0;
         stat_mp_q  <= 32'd0;
      end else begin
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         stat_br_q  <= stat_br_d;
         stat_mp_q  <= stat_mp_d;
      end
   end

   assign flush            = flush_q;
   assign redirect_pc      = redirect_q;
   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] pred_next_pc;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_isbranch;
   logic        mem_isjump;
   logic        mem_pcsrc;
   logic [31:0] mem_target;
   logic        mem_pred_taken;
   logic [31:0] mem_pred_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int n_checks = 0;
   int n_pass   = 0;

   branch_predictor #(.IDX_BITS(6), .TAG_BITS(24)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .pred_next_pc     (pred_next_pc),
      .mem_valid        (mem_valid),
      .mem_pc           (mem_pc),
      .mem_isbranch     (mem_isbranch),
      .mem_isjump       (mem_isjump),
      .mem_pcsrc        (mem_pcsrc),
      .mem_target       (mem_target),
      .mem_pred_taken   (mem_pred_taken),
      .mem_pred_target  (mem_pred_target),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [31:0] pc);
      if_pc = pc;
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic isb, input logic isj,
                        input logic taken, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
      mem_valid       = v;
      mem_pc          = pc;
      mem_isbranch    = isb;
      mem_isjump      = isj;
      mem_pcsrc       = taken;
      mem_target      = tgt;
      mem_pred_taken  = ptk;
      mem_pred_target = ptgt;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic check_reg(input string tag, input logic fl, input logic [31:0] rd,
                            input logic [31:0] nb, input logic [31:0] nm);
      check({tag, ".flush"},    {31'd0, flush}, {31'd0, fl});
      check({tag, ".redirect"}, redirect_pc,    rd);
      check({tag, ".branches"}, stat_branches,  nb);
      check({tag, ".mispred"},  stat_mispredicts, nm);
   endtask

   initial begin
      rst = 1'b1;
      if_pc = 32'h0000_0100;
      idle();
      repeat (2) @(posedge clk);
      #1;
      // 1. reset state
      check("rst.pred_taken", {31'd0, pred_taken}, 32'd0);
      look(32'h0000_0000);
      check("rst.pred_taken0", {31'd0, pred_taken}, 32'd0);
      check("rst.next_pc0", pred_next_pc, 32'h0000_0004);
      check_reg("rst", 1'b0, 32'd0, 32'd0, 32'd0);
      rst = 1'b0;
      tick();

      // 2. first taken branch allocates; same-cycle lookup sees old contents
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
      look(32'h100);
      check("t2.pre_edge_pred", {31'd0, pred_taken}, 32'd0);
      tick();
      check_reg("t2", 1'b1, 32'h80, 32'd1, 32'd1);
      idle();
      look(32'h100);
      check("t2.pred_taken", {31'd0, pred_taken}, 32'd1);
      check("t2.next_pc", pred_next_pc, 32'h80);
      tick();
      check_reg("t2.after", 1'b0, 32'h80, 32'd1, 32'd1);

      // 3. not-taken twice: 10 -> 01 (flush) -> 00 (no flush)
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
      tick();
      check_reg("t3a", 1'b1, 32'h104, 32'd2, 32'd2);
      idle();
      look(32'h100);
      check("t3a.pred_taken", {31'd0, pred_taken}, 32'd0);
      check("t3a.pred_target", pred_target, 32'h80);
      check("t3a.next_pc", pred_next_pc, 32'h104);
      tick();
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
      tick();
      check_reg("t3b", 1'b0, 32'h104, 32'd3, 32'd2);
      // taken once from 00 only reaches 01, still predicting not-taken
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
      tick();
      check_reg("t3c", 1'b1, 32'h80, 32'd4, 32'd3);
      idle();
      look(32'h100);
      check("t3c.pred_taken", {31'd0, pred_taken}, 32'd0);
      tick();

      // 4. jalr predicted to 0x300, resolves to 0x340
      drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h340, 1'b1, 32'h300);
      tick();
      check_reg("t4", 1'b1, 32'h340, 32'd5, 32'd4);
      idle();
      look(32'h200);
      check("t4.pred_taken", {31'd0, pred_taken}, 32'd1);
      check("t4.next_pc", pred_next_pc, 32'h340);
      tick();
      drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h340, 1'b1, 32'h340);
      tick();
      check_reg("t4.correct", 1'b0, 32'h340, 32'd6, 32'd4);

      // 5. 0x100 and 0x200 share index 0; re-train 0x100 then alias at 0x200
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
      tick();
      check_reg("t5.alloc", 1'b1, 32'h80, 32'd7, 32'd5);
      idle();
      tick();
      drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h340);
      tick();
      check_reg("t5.alias", 1'b1, 32'h204, 32'd7, 32'd6);
      idle();
      look(32'h100);
      check("t5.kept", {31'd0, pred_taken}, 32'd1);
      check("t5.kept_next", pred_next_pc, 32'h80);
      look(32'h200);
      check("t5.miss200", {31'd0, pred_taken}, 32'd0);
      tick();
      // alias with matching tag invalidates the entry
      drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
      tick();
      check_reg("t5.inval", 1'b1, 32'h104, 32'd7, 32'd7);
      idle();
      look(32'h100);
      check("t5.inval_pred", {31'd0, pred_taken}, 32'd0);
      check("t5.inval_tgt", pred_target, 32'd0);
      tick();

      // PC+4 wraps at the top of the address space
      look(32'hFFFF_FFFC);
      check("wrap.next_pc", pred_next_pc, 32'd0);
      drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234);
      tick();
      check_reg("wrap.redirect", 1'b1, 32'd0, 32'd7, 32'd8);

      // 6. mispredict presented during the flush cycle is ignored
      drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
      tick();
      check_reg("t6.ignored", 1'b0, 32'd0, 32'd7, 32'd8);
      idle();
      look(32'h300);
      check("t6.no_alloc", {31'd0, pred_taken}, 32'd0);
      drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
      tick();
      check_reg("t6.flush", 1'b1, 32'h500, 32'd8, 32'd9);
      // asynchronous reset during flush
      idle();
      rst = 1'b1;
      #1;
      check_reg("t6.rst", 1'b0, 32'd0, 32'd0, 32'd0);
      look(32'h200);
      check("t6.rst_table", {31'd0, pred_taken}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("t6.post_rst_flush", {31'd0, flush}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
